// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI master:
//   - EDGES_PER_BYTE : SPI_CLK edges generated for one 8-bit transfer
//   - xfer_state_t   : idle/busy state of the master handshake
//   - mode_cpol()    : SPI mode (0-3) -> clock polarity
//   - mode_cpha()    : SPI mode (0-3) -> clock phase
// -----------------------------------------------------------------------------
package spi_pkg;

   localparam int unsigned EDGES_PER_BYTE = 16;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } xfer_state_t;

   // Modes 2 and 3 idle the clock high.
   function automatic logic mode_cpol(input int mode);
      return (mode == 2) || (mode == 3);
   endfunction

   // Modes 1 and 3 launch data on the leading edge.
   function automatic logic mode_cpha(input int mode);
      return (mode == 1) || (mode == 3);
   endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// -----------------------------------------------------------------------------
// spi_clk_gen
// Generates the 16 SPI_CLK edges of one byte transfer.
//
// Parameters
//   CPOL              : idle level of SPI_CLK
//   CLKS_PER_HALF_BIT : clk cycles between consecutive SPI_CLK edges (>= 2)
//
// Ports
//   clk     in  system clock
//   rst     in  synchronous active-high reset, aborts any burst
//   start   in  one-cycle pulse that launches a 16-edge burst
//   spi_clk out serial clock, returns to CPOL after the 16th edge
//   lead    out one-cycle pulse in the cycle after a leading edge
//   trail   out one-cycle pulse in the cycle after a trailing edge
//   done    out one-cycle pulse in the cycle after the 16th edge
// -----------------------------------------------------------------------------
module spi_clk_gen
   import spi_pkg::*;
#(
   parameter logic CPOL              = 1'b0,
   parameter int   CLKS_PER_HALF_BIT = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic spi_clk,
   output logic lead,
   output logic trail,
   output logic done
);

   localparam int HALF_W = $clog2(2 * CLKS_PER_HALF_BIT);
   localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(CLKS_PER_HALF_BIT - 1);

   logic [HALF_W-1:0] half_cnt;
   logic [4:0]        edge_cnt;   // edges still to generate, 16 down to 0

   // NOTE: state registers are updated with <= only, so every flop samples
   // the pre-edge value of its neighbours regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         half_cnt <= '0;
         edge_cnt <= '0;
         spi_clk  <= CPOL;
         lead     <= 1'b0;
         trail    <= 1'b0;
         done     <= 1'b0;
      end else begin
         lead  <= 1'b0;
         trail <= 1'b0;
         done  <= 1'b0;
         if (start) begin
            half_cnt <= '0;
            edge_cnt <= 5'(EDGES_PER_BYTE);
         end else if (edge_cnt != 5'd0) begin
            if (half_cnt == HALF_LAST) begin
               half_cnt <= '0;
               edge_cnt <= edge_cnt - 5'd1;
               spi_clk  <= ~spi_clk;
               // An even remaining count means the first edge of a bit pair.
               lead     <= ~edge_cnt[0];
               trail    <= edge_cnt[0];
               done     <= (edge_cnt == 5'd1);
            end else begin
               half_cnt <= half_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
// Single-byte SPI master, MSB first, SPI mode 0-3.
//
// Parameters
//   SPI_MODE          : 0-3 (CPOL = mode 2/3, CPHA = mode 1/3)
//   CLKS_PER_HALF_BIT : clk cycles per SPI_CLK half-period (>= 2)
//
// Ports
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   i_MOSI_Byte  in   byte to send, captured in the accept cycle
//   i_MOSI_DV    in   transfer request, accepted while o_MOSI_Ready is high
//   o_MOSI_Ready out  idle and able to accept a request
//   o_MISO_DV    out  one-cycle pulse, o_MISO_Byte valid
//   o_MISO_Byte  out  last received byte, held until the next o_MISO_DV
//   SPI_CLK      out  serial clock
//   MISO         in   serial data from slave
//   MOSI         out  serial data to slave, holds last bit when idle
// -----------------------------------------------------------------------------
module spi_master
   import spi_pkg::*;
#(
   parameter int SPI_MODE          = 0,
   parameter int CLKS_PER_HALF_BIT = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] i_MOSI_Byte,
   input  logic       i_MOSI_DV,
   output logic       o_MOSI_Ready,
   output logic       o_MISO_DV,
   output logic [7:0] o_MISO_Byte,
   output logic       SPI_CLK,
   input  logic       MISO,
   output logic       MOSI
);

   localparam logic CPOL = mode_cpol(SPI_MODE);
   localparam logic CPHA = mode_cpha(SPI_MODE);

   xfer_state_t state;
   logic        accept;
   logic        lead;
   logic        trail;
   logic        edge_done;
   logic        sample_stb;
   logic        update_stb;
   logic [7:0]  rx_sr;
   logic [7:0]  rx_next;
   logic [7:0]  tx_sr;
   logic [3:0]  tx_left;    // MOSI bits still to launch

   spi_clk_gen #(
      .CPOL              (CPOL),
      .CLKS_PER_HALF_BIT (CLKS_PER_HALF_BIT)
   ) u_clk_gen (
      .clk     (clk),
      .rst     (rst),
      .start   (accept),
      .spi_clk (SPI_CLK),
      .lead    (lead),
      .trail   (trail),
      .done    (edge_done)
   );

   // NOTE: every signal gets a value at the top of the block, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      accept     = 1'b0;
      sample_stb = 1'b0;
      update_stb = 1'b0;
      rx_next    = rx_sr;
      accept     = (state == ST_IDLE) && o_MOSI_Ready && i_MOSI_DV;
      sample_stb = CPHA ? trail : lead;
      update_stb = CPHA ? lead  : trail;
      if (sample_stb) begin
         rx_next = {rx_sr[6:0], MISO};
      end
   end

   // With CPHA=1 the last sample and the 16th edge coincide, so the output
   // byte is loaded from rx_next to include that final bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the shift registers are cleared with the control flops so
         // MOSI and o_MISO_Byte come out of reset defined; bulk storage
         // arrays would normally be left without reset.
         state        <= ST_IDLE;
         o_MOSI_Ready <= 1'b0;
         o_MISO_DV    <= 1'b0;
         o_MISO_Byte  <= 8'h00;
         MOSI         <= 1'b0;
         rx_sr        <= 8'h00;
         tx_sr        <= 8'h00;
         tx_left      <= 4'd0;
      end else begin
         o_MISO_DV <= 1'b0;
         case (state)
            ST_IDLE: begin
               o_MOSI_Ready <= 1'b1;
               if (accept) begin
                  o_MOSI_Ready <= 1'b0;
                  state        <= ST_BUSY;
                  if (CPHA) begin
                     tx_sr   <= i_MOSI_Byte;
                     tx_left <= 4'd8;
                  end else begin
                     // CPHA=0: bit 7 must be on the line before the first edge.
                     MOSI    <= i_MOSI_Byte[7];
                     tx_sr   <= {i_MOSI_Byte[6:0], 1'b0};
                     tx_left <= 4'd7;
                  end
               end
            end
            ST_BUSY: begin
               rx_sr <= rx_next;
               if (update_stb && (tx_left != 4'd0)) begin
                  MOSI    <= tx_sr[7];
                  tx_sr   <= {tx_sr[6:0], 1'b0};
                  tx_left <= tx_left - 4'd1;
               end
               if (edge_done) begin
                  o_MISO_Byte  <= rx_next;
                  o_MISO_DV    <= 1'b1;
                  o_MOSI_Ready <= 1'b1;
                  state        <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master.sv
// -----------------------------------------------------------------------------
// tb_spi_master
// Four spi_master instances (modes 0-3, four clk cycles per half bit) share
// clk and rst. Every MOSI loops back to its MISO, except that instance 0 can
// be switched to a slave model that returns a preset byte.
// -----------------------------------------------------------------------------
module tb_spi_master;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [3:0]      dv;
   logic [3:0]      ready;
   logic [3:0]      mdv;
   logic [3:0]      sclk;
   logic [3:0]      mosi;
   logic [3:0]      miso;
   logic [3:0][7:0] tx_byte;
   logic [3:0][7:0] rx_byte;

   // Slave model on instance 0 (mode 0: change on falling, capture on rising).
   logic       slave_en   = 1'b0;
   logic [7:0] slave_data = 8'h00;
   logic       slave_en_q = 1'b0;
   logic [7:0] slave_sr   = 8'h00;
   logic [7:0] mosi_cap   = 8'h00;

   // Monitor state, written only by the monitor process.
   int   cyc = 0;
   int   edges [4] = '{0, 0, 0, 0};
   int   dv_cnt[4] = '{0, 0, 0, 0};
   int   hist  [4][16];
   logic [3:0] sclk_prev = 4'h0;

   int checks = 0;
   int errors = 0;

   // Results of the most recent do_xfer call.
   logic       x_ok;
   logic [7:0] x_got;
   int         x_lat;
   int         x_acc;

   always #5 clk = ~clk;

   for (genvar m = 0; m < 4; m++) begin : g_dut
      spi_master #(
         .SPI_MODE          (m),
         .CLKS_PER_HALF_BIT (4)
      ) u_dut (
         .clk          (clk),
         .rst          (rst),
         .i_MOSI_Byte  (tx_byte[m]),
         .i_MOSI_DV    (dv[m]),
         .o_MOSI_Ready (ready[m]),
         .o_MISO_DV    (mdv[m]),
         .o_MISO_Byte  (rx_byte[m]),
         .SPI_CLK      (sclk[m]),
         .MISO         (miso[m]),
         .MOSI         (mosi[m])
      );
   end

   assign miso = {mosi[3:1], slave_en ? slave_sr[7] : mosi[0]};

   always @(posedge clk) cyc <= cyc + 1;

   // Edge history, o_MISO_DV pulse count and the slave model, observed on the
   // falling clk edge away from DUT updates.
   always @(negedge clk) begin
      for (int m = 0; m < 4; m++) begin
         if (sclk[m] !== sclk_prev[m]) begin
            hist[m][edges[m] % 16] <= cyc;
            edges[m]               <= edges[m] + 1;
         end
         if (mdv[m] === 1'b1) dv_cnt[m] <= dv_cnt[m] + 1;
      end
      if (slave_en && !slave_en_q) begin
         slave_sr <= slave_data;
         mosi_cap <= 8'h00;
      end else if (slave_en && (sclk[0] !== sclk_prev[0])) begin
         if (sclk[0] === 1'b1) mosi_cap <= {mosi_cap[6:0], mosi[0]};
         else                  slave_sr <= {slave_sr[6:0], 1'b0};
      end
      sclk_prev  <= sclk;
      slave_en_q <= slave_en;
   end

   // Send one byte on instance m and wait for its o_MISO_DV. x_lat counts
   // falling edges from the accept edge to the one where o_MISO_DV is seen;
   // x_acc is the cycle number of the accept edge.
   task automatic do_xfer(input int m, input logic [7:0] b);
      int n;
      x_ok  = 1'b0;
      x_got = 8'h00;
      n = 0;
      while (ready[m] !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      tx_byte[m] = b;
      dv[m]      = 1'b1;
      @(negedge clk);
      dv[m]      = 1'b0;
      x_acc      = cyc;
      x_lat      = 1;
      while (mdv[m] !== 1'b1 && x_lat < 400) begin
         @(negedge clk);
         x_lat++;
      end
      if (mdv[m] === 1'b1) begin
         x_ok  = 1'b1;
         x_got = rx_byte[m];
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (ready !== 4'h0) begin
         errors++; $display("FAIL reset_ready got=%b exp=%b", ready, 4'h0);
      end
      checks++;
      if (mdv !== 4'h0) begin
         errors++; $display("FAIL reset_dv got=%b exp=%b", mdv, 4'h0);
      end
      checks++;
      if (rx_byte !== 32'h0) begin
         errors++; $display("FAIL reset_rx_byte got=%h exp=%h", rx_byte, 32'h0);
      end
      checks++;
      if (mosi !== 4'h0) begin
         errors++; $display("FAIL reset_mosi got=%b exp=%b", mosi, 4'h0);
      end
      checks++;
      if (sclk !== 4'b1100) begin
         errors++; $display("FAIL reset_sclk got=%b exp=%b", sclk, 4'b1100);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (ready !== 4'hF) begin
         errors++; $display("FAIL release_ready got=%b exp=%b", ready, 4'hF);
      end
   endtask

   task automatic test_loopback_m3();
      int d0;
      d0 = dv_cnt[3];
      do_xfer(3, 8'h37);
      checks++;
      if (x_ok !== 1'b1 || x_got !== 8'h37) begin
         errors++; $display("FAIL m3_loop_37 got=%h ok=%b exp=%h", x_got, x_ok, 8'h37);
      end
      checks++;
      if (x_lat != 66) begin
         errors++; $display("FAIL m3_latency got=%0d exp=%0d", x_lat, 66);
      end
      checks++;
      if (ready[3] !== 1'b1) begin
         errors++; $display("FAIL m3_ready_with_dv got=%b exp=1", ready[3]);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (dv_cnt[3] - d0 != 1) begin
         errors++; $display("FAIL m3_dv_pulses got=%0d exp=1", dv_cnt[3] - d0);
      end
   endtask

   task automatic test_back_to_back();
      int d0;
      d0 = dv_cnt[3];
      do_xfer(3, 8'h38);
      checks++;
      if (x_ok !== 1'b1 || x_got !== 8'h38) begin
         errors++; $display("FAIL b2b_first got=%h ok=%b exp=%h", x_got, x_ok, 8'h38);
      end
      checks++;
      if (sclk[3] !== 1'b1) begin
         errors++; $display("FAIL b2b_sclk_idle got=%b exp=1", sclk[3]);
      end
      // Second request driven in the very cycle o_MISO_DV is high.
      do_xfer(3, 8'h39);
      checks++;
      if (x_ok !== 1'b1 || x_got !== 8'h39) begin
         errors++; $display("FAIL b2b_second got=%h ok=%b exp=%h", x_got, x_ok, 8'h39);
      end
      checks++;
      if (x_lat != 66) begin
         errors++; $display("FAIL b2b_latency got=%0d exp=%0d", x_lat, 66);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (dv_cnt[3] - d0 != 2) begin
         errors++; $display("FAIL b2b_dv_pulses got=%0d exp=2", dv_cnt[3] - d0);
      end
   endtask

   task automatic test_modes();
      for (int m = 0; m < 4; m++) begin
         int   e0;
         int   bad;
         logic exp_cpol;
         exp_cpol = (m >= 2);
         checks++;
         if (sclk[m] !== exp_cpol) begin
            errors++; $display("FAIL mode%0d_idle_before got=%b exp=%b", m, sclk[m], exp_cpol);
         end
         e0 = edges[m];
         do_xfer(m, 8'hA5);
         checks++;
         if (x_ok !== 1'b1 || x_got !== 8'hA5) begin
            errors++; $display("FAIL mode%0d_loop_a5 got=%h ok=%b exp=%h", m, x_got, x_ok, 8'hA5);
         end
         checks++;
         if (x_lat != 66) begin
            errors++; $display("FAIL mode%0d_latency got=%0d exp=%0d", m, x_lat, 66);
         end
         repeat (4) @(negedge clk);
         checks++;
         if (edges[m] - e0 != 16) begin
            errors++; $display("FAIL mode%0d_edges got=%0d exp=16", m, edges[m] - e0);
         end
         checks++;
         if (hist[m][e0 % 16] != x_acc + 4) begin
            errors++; $display("FAIL mode%0d_first_edge got=%0d exp=%0d", m, hist[m][e0 % 16], x_acc + 4);
         end
         bad = 0;
         for (int k = 1; k < 16; k++) begin
            if (hist[m][(e0 + k) % 16] - hist[m][(e0 + k - 1) % 16] != 4) bad++;
         end
         checks++;
         if (bad != 0) begin
            errors++; $display("FAIL mode%0d_half_period bad_gaps=%0d exp=0", m, bad);
         end
         checks++;
         if (sclk[m] !== exp_cpol) begin
            errors++; $display("FAIL mode%0d_idle_after got=%b exp=%b", m, sclk[m], exp_cpol);
         end
         checks++;
         if (mosi[m] !== 1'b1) begin
            errors++; $display("FAIL mode%0d_mosi_hold got=%b exp=1", m, mosi[m]);
         end
      end
   endtask

   task automatic test_slave_m0();
      slave_data = 8'h5A;
      slave_en   = 1'b1;
      repeat (2) @(negedge clk);
      do_xfer(0, 8'hC3);
      checks++;
      if (x_ok !== 1'b1 || x_got !== 8'h5A) begin
         errors++; $display("FAIL slave_miso got=%h ok=%b exp=%h", x_got, x_ok, 8'h5A);
      end
      checks++;
      if (mosi_cap !== 8'hC3) begin
         errors++; $display("FAIL slave_mosi_bits got=%b exp=%b", mosi_cap, 8'hC3);
      end
      slave_en = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_ignore_busy();
      int e0;
      int d0;
      int n;
      e0 = edges[3];
      d0 = dv_cnt[3];
      n  = 0;
      while (ready[3] !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      tx_byte[3] = 8'h12;
      dv[3]      = 1'b1;
      @(negedge clk);
      dv[3]      = 1'b0;
      checks++;
      if (ready[3] !== 1'b0) begin
         errors++; $display("FAIL ignore_ready_low got=%b exp=0", ready[3]);
      end
      repeat (20) @(negedge clk);
      tx_byte[3] = 8'hFF;
      dv[3]      = 1'b1;
      @(negedge clk);
      dv[3]      = 1'b0;
      tx_byte[3] = 8'h00;
      n = 0;
      while (mdv[3] !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (mdv[3] !== 1'b1 || rx_byte[3] !== 8'h12) begin
         errors++; $display("FAIL ignore_result got=%h dv=%b exp=%h", rx_byte[3], mdv[3], 8'h12);
      end
      repeat (80) @(negedge clk);
      checks++;
      if (edges[3] - e0 != 16 || dv_cnt[3] - d0 != 1) begin
         errors++; $display("FAIL ignore_no_extra edges=%0d dv=%0d exp=16/1", edges[3] - e0, dv_cnt[3] - d0);
      end
   endtask

   task automatic test_reset_abort();
      int e0;
      int d0;
      int n;
      e0 = edges[3];
      n  = 0;
      while (ready[3] !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      tx_byte[3] = 8'h81;
      dv[3]      = 1'b1;
      @(negedge clk);
      dv[3]      = 1'b0;
      n = 0;
      while (edges[3] - e0 < 5 && n < 200) begin
         @(negedge clk);
         n++;
      end
      d0  = dv_cnt[3];
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (sclk[3] !== 1'b1 || ready[3] !== 1'b0 || mosi[3] !== 1'b0) begin
         errors++; $display("FAIL abort_reset_state sclk=%b ready=%b mosi=%b exp=1/0/0", sclk[3], ready[3], mosi[3]);
      end
      checks++;
      if (rx_byte[3] !== 8'h00 || mdv[3] !== 1'b0) begin
         errors++; $display("FAIL abort_reset_rx got=%h dv=%b exp=00/0", rx_byte[3], mdv[3]);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (ready[3] !== 1'b1) begin
         errors++; $display("FAIL abort_ready_release got=%b exp=1", ready[3]);
      end
      repeat (80) @(negedge clk);
      checks++;
      if (dv_cnt[3] != d0) begin
         errors++; $display("FAIL abort_no_dv got=%0d exp=0", dv_cnt[3] - d0);
      end
      do_xfer(3, 8'h3C);
      checks++;
      if (x_ok !== 1'b1 || x_got !== 8'h3C) begin
         errors++; $display("FAIL abort_next_xfer got=%h ok=%b exp=%h", x_got, x_ok, 8'h3C);
      end
      checks++;
      if (x_lat != 66) begin
         errors++; $display("FAIL abort_next_latency got=%0d exp=%0d", x_lat, 66);
      end
   endtask

   initial begin
      dv      = 4'h0;
      tx_byte = '0;
      rst     = 1'b1;
      test_reset();
      test_loopback_m3();
      test_back_to_back();
      test_modes();
      test_slave_m0();
      test_ignore_busy();
      test_reset_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
